wb_rr_arbiter: RTL and testbench

//  Round-robin arbiter that shares one Wishbone slave bus (sw_reg_wr/sw_reg_rd banks, BRAM slaves)

---
 rtl/wb_rr_arbiter_pkg.sv | 22 ++
 rtl/rr_pick.sv | 31 +++
 rtl/wb_rr_arbiter.sv | 129 ++++++++++++
 tb/tb_wb_rr_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_rr_arbiter_pkg.sv
// Shared definitions for the Wishbone round-robin arbiter: FSM encoding,
// byte-enable width derivation and a constant-safe clog2.
package wb_rr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++)
      if ((32'd1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int unsigned byte_en_width(input int unsigned dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester searching upward from
// (last+1) mod N, wrapping; returns one-hot winner, its index and a found flag.
module rr_pick #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  win,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  always_comb begin
    win  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      cand = IW'((32'(last) + off) % N);
      if (!any && req[cand]) begin
        any       = 1'b1;
        win[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: grants whole cyc-to-cyc cycles to one of
// NUM_MASTERS masters, muxes it onto the slave bus and aborts hung cycles.
module wb_rr_arbiter
  import wb_rr_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_MASTERS    = 2,
  parameter  int unsigned BUS_DATA_WIDTH = 32,
  parameter  int unsigned BUS_ADDR_WIDTH = 8,
  parameter  int unsigned TIMEOUT        = 255,
  localparam int unsigned BE_W           = byte_en_width(BUS_DATA_WIDTH)
) (
  input  logic                                wb_clk_i,
  input  logic                                wb_rst_i,
  input  logic [NUM_MASTERS-1:0]              wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]              wbm_stb_i,
  input  logic [NUM_MASTERS-1:0]              wbm_we_i,
  input  logic [NUM_MASTERS*BE_W-1:0]         wbm_sel_i,
  input  logic [NUM_MASTERS*BUS_ADDR_WIDTH-1:0] wbm_adr_i,
  input  logic [NUM_MASTERS*BUS_DATA_WIDTH-1:0] wbm_dat_i,
  output logic [BUS_DATA_WIDTH-1:0]           wbm_dat_o,
  output logic [NUM_MASTERS-1:0]              wbm_ack_o,
  output logic [NUM_MASTERS-1:0]              wbm_err_o,
  output logic                                wbs_cyc_o,
  output logic                                wbs_stb_o,
  output logic                                wbs_we_o,
  output logic [BE_W-1:0]                     wbs_sel_o,
  output logic [BUS_ADDR_WIDTH-1:0]           wbs_adr_o,
  output logic [BUS_DATA_WIDTH-1:0]           wbs_dat_o,
  input  logic [BUS_DATA_WIDTH-1:0]           wbs_dat_i,
  input  logic                                wbs_ack_i,
  output logic [NUM_MASTERS-1:0]              gnt_o
);

  localparam int unsigned IW = clog2(NUM_MASTERS);

  state_t                 state, state_nx;
  logic [NUM_MASTERS-1:0] gnt_nx;
  logic [IW-1:0]          last, last_nx;
  logic [NUM_MASTERS-1:0] pick_win;
  logic [IW-1:0]          pick_idx;
  logic                   pick_any;
  logic                   active, cyc_g, stb_raw, abort;

  rr_pick #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_pick (
    .req  (wbm_cyc_i),
    .last (last),
    .win  (pick_win),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // The last-winner pointer doubles as the mux select while granted.
  assign active  = |gnt_o;
  assign cyc_g   = active & wbm_cyc_i[last];
  assign stb_raw = cyc_g & wbm_stb_i[last];

  if (TIMEOUT > 0) begin : g_wd
    localparam int unsigned WDW = clog2(TIMEOUT + 1);
    logic [WDW-1:0] wd;

    // Ack in the terminal cycle suppresses the abort.
    assign abort = stb_raw & ~wbs_ack_i & (wd == WDW'(TIMEOUT));

    always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || state != ST_GRANT || !stb_raw || wbs_ack_i || abort)
        wd <= '0;
      else
        wd <= wd + 1'b1;
    end
  end else begin : g_no_wd
    assign abort = 1'b0;
  end

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt_o;
    last_nx  = last;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          state_nx = ST_GRANT;
          gnt_nx   = pick_win;
          last_nx  = pick_idx;
        end
      end
      ST_GRANT: begin
        if (!cyc_g || abort) begin
          state_nx = ST_IDLE;
          gnt_nx   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= ST_IDLE;
      gnt_o <= '0;
      last  <= IW'(NUM_MASTERS - 1);
    end else begin
      state <= state_nx;
      gnt_o <= gnt_nx;
      last  <= last_nx;
    end
  end

  always_comb begin
    wbs_we_o  = 1'b0;
    wbs_sel_o = '0;
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    if (active) begin
      wbs_we_o  = wbm_we_i[last];
      wbs_sel_o = wbm_sel_i[last*BE_W +: BE_W];
      wbs_adr_o = wbm_adr_i[last*BUS_ADDR_WIDTH +: BUS_ADDR_WIDTH];
      wbs_dat_o = wbm_dat_i[last*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
    end
  end

  assign wbs_cyc_o = cyc_g & ~abort;
  assign wbs_stb_o = stb_raw & ~abort;
  assign wbm_dat_o = wbs_dat_i;
  assign wbm_ack_o = gnt_o & {NUM_MASTERS{wbs_ack_i & wbs_stb_o}};
  assign wbm_err_o = gnt_o & {NUM_MASTERS{abort}};

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Scoreboard bench for wb_rr_arbiter: stub slave with programmable ack delay,
// round-robin/memory reference model, monitor checking every ack/err.
module tb_wb_rr_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 8;
  localparam int unsigned BEW = 4;
  localparam int unsigned TMO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]     cyc, stb, we;
  logic [N*BEW-1:0] sel;
  logic [N*AW-1:0]  adr;
  logic [N*DW-1:0]  dat;
  logic [DW-1:0]    mdat;
  logic [N-1:0]     ack_o, err_o, gnt;
  logic             s_cyc, s_stb, s_we, s_ack;
  logic [BEW-1:0]   s_sel;
  logic [AW-1:0]    s_adr;
  logic [DW-1:0]    s_dat_o, s_dat_i;

  wb_rr_arbiter #(
    .NUM_MASTERS    (N),
    .BUS_DATA_WIDTH (DW),
    .BUS_ADDR_WIDTH (AW),
    .TIMEOUT        (TMO)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbm_cyc_i (cyc),
    .wbm_stb_i (stb),
    .wbm_we_i  (we),
    .wbm_sel_i (sel),
    .wbm_adr_i (adr),
    .wbm_dat_i (dat),
    .wbm_dat_o (mdat),
    .wbm_ack_o (ack_o),
    .wbm_err_o (err_o),
    .wbs_cyc_o (s_cyc),
    .wbs_stb_o (s_stb),
    .wbs_we_o  (s_we),
    .wbs_sel_o (s_sel),
    .wbs_adr_o (s_adr),
    .wbs_dat_o (s_dat_o),
    .wbs_dat_i (s_dat_i),
    .wbs_ack_i (s_ack),
    .gnt_o     (gnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, got, want, $time);
    end
  endtask

  // Stub slave: ack arrives ack_delay cycles after stb first appears.
  logic [DW-1:0] smem [256];
  logic          ack_r;
  int unsigned   wait_cnt;
  int unsigned   ack_delay = 1;
  assign s_ack = ack_r;
  always_comb s_dat_i = smem[s_adr];

  always @(posedge clk) begin
    if (rst) begin
      ack_r    <= 1'b0;
      wait_cnt <= 0;
      for (int i = 0; i < 256; i++) smem[i] <= '0;
    end else begin
      if (ack_r && s_cyc && s_stb && s_we)
        for (int b = 0; b < 4; b++)
          if (s_sel[b]) smem[s_adr][b*8 +: 8] <= s_dat_o[b*8 +: 8];
      if (s_cyc && s_stb && !ack_r) begin
        ack_r    <= (wait_cnt + 1 >= ack_delay);
        wait_cnt <= wait_cnt + 1;
      end else begin
        ack_r    <= 1'b0;
        wait_cnt <= 0;
      end
    end
  end

  typedef struct {
    int unsigned m;
    bit          is_err;
    bit          is_rd;
    logic [31:0] data;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mmem [256];
  int unsigned m_last;
  bit          t_we  [N];
  logic [7:0]  t_adr [N];
  logic [3:0]  t_sel [N];
  logic [31:0] t_dat [N];

  // Monitor: one-hot invariants every cycle, scoreboard pop on any response.
  exp_t mon_e;
  int   mon_idx;
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      assert ($onehot0(gnt) && $onehot0(ack_o) && $onehot0(err_o) && ((ack_o & err_o) == '0))
      else begin
        errors++;
        $display("FAIL onehot: gnt=%b ack=%b err=%b required one-hot or zero", gnt, ack_o, err_o);
      end
      if ((ack_o | err_o) != '0) begin
        mon_idx = -1;
        for (int i = N - 1; i >= 0; i--) if (ack_o[i] | err_o[i]) mon_idx = i;
        if (sbq.size() == 0) begin
          check(1'b0, "unexpected_response", 64'(ack_o | err_o), 64'd0);
        end else begin
          mon_e = sbq.pop_front();
          check(mon_idx == int'(mon_e.m), "resp_master", 64'(mon_idx), 64'(mon_e.m));
          check((err_o != '0) == mon_e.is_err, "resp_is_err", 64'(err_o != '0), 64'(mon_e.is_err));
          if (mon_e.is_rd && !mon_e.is_err)
            check(mdat == mon_e.data, "read_data", 64'(mdat), 64'(mon_e.data));
        end
      end
    end
  end

  task automatic model_reset();
    m_last = N - 1;
    sbq.delete();
    for (int i = 0; i < 256; i++) mmem[i] = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    cyc = '0; stb = '0; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // All masters in mask request together; each holds cyc until its ack/err.
  task automatic run_round(input logic [N-1:0] mask, input int unsigned dly);
    int unsigned order[$];
    logic [N-1:0] rem, pend, done, prev_g, eg;
    int unsigned pos;
    int unsigned j;
    exp_t e;
    int cycn, stb_c, k;
    bit post_err, found;

    rem = mask;
    pos = m_last;
    while (rem != '0) begin
      found = 1'b0;
      for (int unsigned off = 1; off <= N; off++) begin
        j = (pos + off) % N;
        if (!found && rem[j]) begin
          found = 1'b1;
          order.push_back(j);
          rem[j] = 1'b0;
          pos = j;
        end
      end
    end
    m_last = pos;
    foreach (order[q]) begin
      j = order[q];
      e.m = j; e.is_err = (dly > TMO); e.is_rd = !t_we[j]; e.data = '0;
      if (!e.is_err) begin
        if (t_we[j]) begin
          for (int b = 0; b < 4; b++)
            if (t_sel[j][b]) mmem[t_adr[j]][b*8 +: 8] = t_dat[j][b*8 +: 8];
        end else begin
          e.data = mmem[t_adr[j]];
        end
      end
      sbq.push_back(e);
    end

    ack_delay = dly;
    @(posedge clk); #1;
    for (int unsigned i = 0; i < N; i++) begin
      if (mask[i]) begin
        cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = t_we[i];
        sel[i*BEW +: BEW] = t_sel[i];
        adr[i*AW +: AW]   = t_adr[i];
        dat[i*DW +: DW]   = t_dat[i];
      end
    end

    pend = mask; prev_g = '0; cycn = 0; stb_c = -1; k = 0; post_err = 1'b0;
    while (pend != '0 && cycn < 200) begin
      @(negedge clk);
      cycn++;
      if (cycn == 1) check(gnt == '0, "grant_latency", 64'(gnt), 64'd0);
      if (post_err) begin
        check(gnt == '0, "err_drops_grant", 64'(gnt), 64'd0);
        post_err = 1'b0;
      end
      if (gnt != prev_g && gnt != '0) begin
        eg = '0;
        if (k < order.size()) eg[order[k]] = 1'b1;
        check(prev_g == '0, "idle_between_grants", 64'(prev_g), 64'd0);
        check(gnt == eg, "grant_order", 64'(gnt), 64'(eg));
        k++;
        stb_c = -1;
      end
      if (s_stb && stb_c < 0) stb_c = cycn;
      if (err_o != '0) begin
        check(cycn - stb_c == int'(TMO), "err_timing", 64'(cycn - stb_c), 64'(TMO));
        check(!s_cyc && !s_stb, "err_forces_idle", {62'd0, s_cyc, s_stb}, 64'd0);
        post_err = 1'b1;
      end
      if (ack_o != '0)
        check(cycn - stb_c == int'(dly), "ack_latency", 64'(cycn - stb_c), 64'(dly));
      done   = (ack_o | err_o) & pend;
      prev_g = gnt;
      @(posedge clk); #1;
      cyc  = cyc & ~done;
      stb  = stb & ~done;
      pend = pend & ~done;
    end
    if (pend != '0) begin
      check(1'b0, "round_timeout", 64'(pend), 64'd0);
      cyc = '0; stb = '0;
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cyc = '1; stb = '1; we = '0; sel = '0; adr = '0; dat = '0;
    for (int i = 0; i < N; i++) begin
      t_we[i] = 1'b0; t_adr[i] = '0; t_sel[i] = '0; t_dat[i] = '0;
    end
    model_reset();

    // Reset held with every master requesting.
    repeat (3) begin
      @(negedge clk);
      check(gnt == '0, "reset_gnt", 64'(gnt), 64'd0);
      check({s_cyc, s_stb, s_we} == 3'b000, "reset_wbs_ctl", 64'({s_cyc, s_stb, s_we}), 64'd0);
      check({s_sel, s_adr, s_dat_o} == '0, "reset_wbs_payload", 64'({s_sel, s_adr}), 64'd0);
      check((ack_o | err_o) == '0, "reset_ack_err", 64'(ack_o | err_o), 64'd0);
    end
    @(posedge clk); #1;
    cyc = '0; stb = '0; rst = 1'b0;

    // Contention between m0 and m1: strict alternation.
    t_we[0] = 1'b0; t_adr[0] = 8'h00;
    t_we[1] = 1'b0; t_adr[1] = 8'h00;
    run_round(4'b0011, 1);
    run_round(4'b0011, 1);

    // Single master write then readback.
    t_we[1] = 1'b1; t_adr[1] = 8'h00; t_sel[1] = 4'hA; t_dat[1] = 32'hEE00EE00;
    run_round(4'b0010, 1);
    t_we[1] = 1'b0;
    run_round(4'b0010, 1);

    // Reset in the middle of an m1 read.
    ack_delay = 3;
    @(posedge clk); #1;
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[AW +: AW] = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check(gnt == 4'b0010, "pre_reset_grant", 64'(gnt), 64'h2);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check(gnt == '0, "mid_reset_gnt", 64'(gnt), 64'd0);
    check(!s_cyc && !s_stb, "mid_reset_wbs", {62'd0, s_cyc, s_stb}, 64'd0);
    @(posedge clk); #1;
    cyc = '0; stb = '0; rst = 1'b0;
    model_reset();
    t_we[0] = 1'b0; t_we[1] = 1'b0;
    run_round(4'b0011, 1);

    // Wrap-around: last=3 -> m0 wins, then last=0 -> m3.
    do_reset();
    t_we[3] = 1'b0; t_adr[3] = 8'h01;
    run_round(4'b1001, 1);

    // Watchdog: never acked, acked exactly at the limit, one past it.
    t_we[2] = 1'b1; t_adr[2] = 8'h05; t_sel[2] = 4'hF; t_dat[2] = 32'h12345678;
    run_round(4'b0100, 1000);
    run_round(4'b0100, TMO);
    t_we[2] = 1'b0;
    run_round(4'b0100, TMO + 1);
    run_round(4'b0100, 1);

    // Randomized rounds.
    for (int r = 0; r < 60; r++) begin
      for (int i = 0; i < N; i++) begin
        t_we[i]  = 1'($urandom_range(0, 1));
        t_adr[i] = 8'($urandom_range(0, 7));
        t_sel[i] = 4'($urandom_range(0, 15));
        t_dat[i] = $urandom;
      end
      run_round(4'($urandom_range(1, 15)), $urandom_range(1, 6));
    end

    check(sbq.size() == 0, "scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
